// File: rtl/irq_ctrl_if.sv
// Interrupt-side signals of irq_ctrl: per-source request/acknowledge and the processor
// raise/acknowledge pair. The controller connects through the slave modport.
interface irq_ctrl_if #(
    parameter int unsigned NUM_SRC = 8
);
    logic [NUM_SRC-1:0] SRC_RAISE;
    logic [NUM_SRC-1:0] SRC_ACK;
    logic               CPU_IRQ_RAISE;
    logic               CPU_IRQ_ACK;

    modport master (
        output SRC_RAISE,
        input  SRC_ACK,
        input  CPU_IRQ_RAISE,
        output CPU_IRQ_ACK
    );

    modport slave (
        input  SRC_RAISE,
        output SRC_ACK,
        output CPU_IRQ_RAISE,
        input  CPU_IRQ_ACK
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: up to eight interrupt sources folded onto one processor raise/ack pair,
// with PENDING/MASK/VECTOR/MODE registers. Define IRQ_CTRL_EDGE_EN for edge mode support.
module irq_ctrl #(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [7:0]  BASE_ADDR = 8'hD0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    irq_ctrl_if.slave  irq
);
    typedef enum logic [1:0] {IDLE, RAISE, SERVICE} state_e;

    state_e             state_q;
    logic               raise_q;
    logic [2:0]         isr_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic               rd_en_q, rd_en_d;
    logic [7:0]         rdata_q, rdata_d;

    logic [8:0]         addr_diff;
    logic               hit, wr, eoi;
    logic [1:0]         off;
    logic [NUM_SRC-1:0] wdata, elig, set_v, clr_v;
    logic               vec_valid;
    logic [2:0]         vec_idx;
    logic [7:0]         mode_rd;

    // Nine-bit difference keeps the window correct for bases near the top of the map.
    assign addr_diff = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
    assign hit       = (addr_diff[8:2] == '0);
    assign off       = addr_diff[1:0];
    assign wr        = BUS_WE && hit;
    assign eoi       = wr && (off == 2'd2);
    assign wdata     = BUS_DATA[NUM_SRC-1:0];
    assign elig      = pend_q & mask_q;

`ifdef IRQ_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] mode_q, mode_d, hist_q;

    // Level sources set whenever high; edge sources only when the registered copy was low.
    assign set_v   = irq.SRC_RAISE & (~mode_q | ~hist_q);
    assign mode_rd = 8'(mode_q);

    always_comb begin
        mode_d = mode_q;
        if (wr && off == 2'd3) mode_d = wdata;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mode_q <= '0;
            hist_q <= '0;
        end else begin
            mode_q <= mode_d;
            hist_q <= irq.SRC_RAISE;
        end
    end
`else
    assign set_v   = irq.SRC_RAISE;
    assign mode_rd = '0;
`endif

    always_comb begin
        vec_valid = |elig;
        vec_idx   = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (elig[i-1]) vec_idx = 3'(i - 1);
        end
    end

    always_comb begin
        clr_v = '0;
        if (wr && off == 2'd0) clr_v = wdata;
        if (eoi && state_q == SERVICE) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (3'(i) == isr_q) clr_v[i] = 1'b1;
            end
        end
        // Set beats clear; an acknowledge goes out only for bits that really drop.
        pend_d = (pend_q & ~clr_v) | set_v;
        ack_d  = pend_q & ~pend_d;
        mask_d = mask_q;
        if (wr && off == 2'd1) mask_d = wdata;
    end

    always_comb begin
        rd_en_d = !BUS_WE && hit;
        rdata_d = '0;
        case (off)
            2'd0:    rdata_d = 8'(pend_q);
            2'd1:    rdata_d = 8'(mask_q);
            2'd2:    rdata_d = {vec_valid, 4'b0000, vec_idx};
            default: rdata_d = mode_rd;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pend_q  <= '0;
            mask_q  <= '0;
            ack_q   <= '0;
            rd_en_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            ack_q   <= ack_d;
            rd_en_q <= rd_en_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            raise_q <= 1'b0;
            isr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vec_valid) begin
                        state_q <= RAISE;
                        raise_q <= 1'b1;
                    end
                end
                RAISE: begin
                    if (!vec_valid) begin
                        state_q <= IDLE;
                        raise_q <= 1'b0;
                    end else if (irq.CPU_IRQ_ACK) begin
                        isr_q   <= vec_idx;
                        state_q <= SERVICE;
                        raise_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    raise_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq.SRC_ACK       = ack_q;
    assign irq.CPU_IRQ_RAISE = raise_q;
    assign BUS_DATA          = rd_en_q ? rdata_q : 'z;
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_irq_ctrl;
    localparam logic [7:0] A_PEND = 8'hD0, A_MASK = 8'hD1, A_VEC = 8'hD2, A_MODE = 8'hD3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_addr = 8'h00;
    logic [7:0] tb_wdata = 8'h00;
    logic       bus_we = 1'b0;
    tri1  [7:0] bus_data;

    assign bus_data = bus_we ? tb_wdata : 8'bz;

    irq_ctrl_if #(.NUM_SRC(8)) irq_bus ();

    irq_ctrl #(.NUM_SRC(8), .BASE_ADDR(8'hD0)) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .BUS_ADDR (bus_addr),
        .BUS_DATA (bus_data),
        .BUS_WE   (bus_we),
        .irq      (irq_bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: plain per-source bit vectors and a busy/raise pair.
    bit [7:0] m_pend, m_mask, m_mode, m_prev, m_ack, m_rdata;
    bit       m_rdv, m_raise, m_busy;
    int       m_isr;

    always @(posedge clk) begin : model_blk
        bit [7:0] nxt;
        bit [7:0] src;
        int       best;
        bit       hit, is_wr, is_eoi, edge_sel;
        int       off;
        src  = irq_bus.SRC_RAISE;
        best = -1;
        for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) best = i;
        if (!rst_n) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0; m_ack = '0;
            m_rdv = 1'b0; m_rdata = '0; m_raise = 1'b0; m_busy = 1'b0; m_isr = 0;
        end else begin
            hit    = (bus_addr >= A_PEND) && (bus_addr <= A_MODE);
            off    = int'(bus_addr) - int'(A_PEND);
            is_wr  = bus_we && hit;
            is_eoi = is_wr && off == 2;
            m_rdv  = !bus_we && hit;
            if (m_rdv) begin
                case (off)
                    0: m_rdata = m_pend;
                    1: m_rdata = m_mask;
                    2: m_rdata = (best >= 0) ? 8'(8'h80 + best) : 8'h00;
                    default: m_rdata = m_mode;
                endcase
            end
            nxt = m_pend;
            if (is_wr && off == 0) nxt = nxt & ~tb_wdata;
            if (is_eoi && m_busy) nxt[m_isr] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                edge_sel = m_mode[i];
                if (edge_sel ? (src[i] && !m_prev[i]) : src[i]) nxt[i] = 1'b1;
            end
            m_ack  = m_pend & ~nxt;
            m_pend = nxt;
            if (is_wr && off == 1) m_mask = tb_wdata;
`ifdef IRQ_CTRL_EDGE_EN
            if (is_wr && off == 3) m_mode = tb_wdata;
`endif
            m_prev = src;
            if (m_busy) begin
                if (is_eoi) m_busy = 1'b0;
            end else if (m_raise) begin
                if (best < 0) m_raise = 1'b0;
                else if (irq_bus.CPU_IRQ_ACK) begin
                    m_isr = best; m_raise = 1'b0; m_busy = 1'b1;
                end
            end else if (best >= 0) begin
                m_raise = 1'b1;
            end
        end
        #2;
        check("cyc_raise", {7'b0, irq_bus.CPU_IRQ_RAISE}, {7'b0, m_raise});
        check("cyc_src_ack", irq_bus.SRC_ACK, m_ack);
        if (!bus_we) check("cyc_bus_data", bus_data, m_rdv ? m_rdata : 8'hFF);
    end

    // Bus tasks start at a falling edge and return at a falling edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_we = 1'b1; bus_addr = a; tb_wdata = d;
        @(negedge clk);
        bus_we = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        bus_addr = a;
        @(negedge clk);
        check(name, bus_data, exp);
        bus_addr = 8'h00;
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        irq_bus.CPU_IRQ_ACK = 1'b1;
        @(negedge clk);
        irq_bus.CPU_IRQ_ACK = 1'b0;
    endtask

    function automatic logic [7:0] raise_v();
        return {7'b0, irq_bus.CPU_IRQ_RAISE};
    endfunction

    initial begin
        irq_bus.SRC_RAISE   = '0;
        irq_bus.CPU_IRQ_ACK = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_raise", raise_v(), 8'h00);
        check("rst_src_ack", irq_bus.SRC_ACK, 8'h00);
        check("rst_bus_z", bus_data, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        rd("rst_pend", A_PEND, 8'h00);
        rd("rst_mask", A_MASK, 8'h00);
        rd("rst_vec", A_VEC, 8'h00);
        rd("rst_mode", A_MODE, 8'h00);
        check("idle_bus_z", bus_data, 8'hFF);

        // Two simultaneous sources: lowest index first, second re-raised after EOI.
        wr(A_MASK, 8'h05);
        irq_bus.SRC_RAISE = 8'h05;
        @(negedge clk);
        check("prio_raise_early", raise_v(), 8'h00);
        irq_bus.SRC_RAISE = 8'h00;
        @(negedge clk);
        check("prio_raise_2cyc", raise_v(), 8'h01);
        rd("prio_vec0", A_VEC, 8'h80);
        pulse_ack();
        check("prio_ack_drop", raise_v(), 8'h00);
        wr(A_VEC, 8'h00);
        check("prio_eoi_ack0", irq_bus.SRC_ACK, 8'h01);
        @(negedge clk);
        check("prio_reraise", raise_v(), 8'h01);
        check("prio_ack_single", irq_bus.SRC_ACK, 8'h00);
        rd("prio_vec2", A_VEC, 8'h82);
        pulse_ack();
        wr(A_VEC, 8'h00);
        check("prio_eoi_ack2", irq_bus.SRC_ACK, 8'h04);
        rd("prio_pend_empty", A_PEND, 8'h00);

        // One-cycle pulse on a masked-in source.
        wr(A_MASK, 8'h02);
`ifdef IRQ_CTRL_EDGE_EN
        wr(A_MODE, 8'h02);
`endif
        irq_bus.SRC_RAISE = 8'h02;
        @(negedge clk);
        irq_bus.SRC_RAISE = 8'h00;
        @(negedge clk);
        check("pulse_raise", raise_v(), 8'h01);
        rd("pulse_pend", A_PEND, 8'h02);
        wr(A_PEND, 8'h02);
        check("pulse_clr_ack", irq_bus.SRC_ACK, 8'h02);
        @(negedge clk);
        check("pulse_cancel", raise_v(), 8'h00);

`ifdef IRQ_CTRL_EDGE_EN
        // Held edge source sets pending only once.
        irq_bus.SRC_RAISE = 8'h02;
        repeat (3) @(negedge clk);
        check("edge_raise", raise_v(), 8'h01);
        pulse_ack();
        wr(A_VEC, 8'h00);
        check("edge_eoi_ack", irq_bus.SRC_ACK, 8'h02);
        rd("edge_no_reset", A_PEND, 8'h00);
        repeat (3) @(negedge clk);
        check("edge_stay_idle", raise_v(), 8'h00);
        rd("edge_no_reset2", A_PEND, 8'h00);
        irq_bus.SRC_RAISE = 8'h00;
        @(negedge clk);
        wr(A_MODE, 8'h00);
`endif

        // Level source: a clear does not stick while the source is high.
        irq_bus.SRC_RAISE = 8'h02;
        repeat (3) @(negedge clk);
        check("lvl_raise", raise_v(), 8'h01);
        wr(A_PEND, 8'h02);
        check("lvl_no_ack", irq_bus.SRC_ACK, 8'h00);
        rd("lvl_still_pend", A_PEND, 8'h02);
        irq_bus.SRC_RAISE = 8'h00;
        wr(A_PEND, 8'h02);
        check("lvl_clr_ack", irq_bus.SRC_ACK, 8'h02);
        repeat (2) @(negedge clk);
        check("lvl_idle", raise_v(), 8'h00);

        // Masking away the only source cancels the request; a late ack is ignored.
        wr(A_MASK, 8'h01);
        irq_bus.SRC_RAISE = 8'h01;
        @(negedge clk);
        irq_bus.SRC_RAISE = 8'h00;
        @(negedge clk);
        check("mask_raise", raise_v(), 8'h01);
        wr(A_MASK, 8'h00);
        check("mask_raise_hold", raise_v(), 8'h01);
        @(negedge clk);
        check("mask_drop", raise_v(), 8'h00);
        pulse_ack();
        @(negedge clk);
        check("mask_ack_ignored", raise_v(), 8'h00);
        rd("mask_pend_kept", A_PEND, 8'h01);
        rd("mask_vec_invalid", A_VEC, 8'h00);
        wr(A_PEND, 8'h01);
        check("mask_clr_ack", irq_bus.SRC_ACK, 8'h01);

        // Set and clear of the same bit in one cycle: set wins.
        irq_bus.SRC_RAISE = 8'h04;
        @(negedge clk);
        irq_bus.SRC_RAISE = 8'h00;
        @(negedge clk);
        irq_bus.SRC_RAISE = 8'h04;
        bus_we = 1'b1; bus_addr = A_PEND; tb_wdata = 8'h04;
        @(negedge clk);
        bus_we = 1'b0; bus_addr = 8'h00; irq_bus.SRC_RAISE = 8'h00;
        check("setwin_no_ack", irq_bus.SRC_ACK, 8'h00);
        check("setwin_model", m_pend, 8'h04);
        rd("setwin_pend", A_PEND, 8'h04);

        // Reset in the middle of service.
        wr(A_MASK, 8'h04);
        repeat (2) @(negedge clk);
        check("svc_raise", raise_v(), 8'h01);
        pulse_ack();
        check("svc_entered", raise_v(), 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        check("svc_rst_raise", raise_v(), 8'h00);
        check("svc_rst_no_ack", irq_bus.SRC_ACK, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("svc_rst_no_ack2", irq_bus.SRC_ACK, 8'h00);
        rd("svc_pend", A_PEND, 8'h00);
        rd("svc_mask", A_MASK, 8'h00);
        rd("svc_vec", A_VEC, 8'h00);
        rd("svc_mode", A_MODE, 8'h00);

        // MODE register writability depends on the build.
        wr(A_MODE, 8'hFF);
`ifdef IRQ_CTRL_EDGE_EN
        rd("mode_rb", A_MODE, 8'hFF);
`else
        rd("mode_rb", A_MODE, 8'h00);
`endif
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
